calc_ctrl: RTL

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl_pkg.sv | 55 +++++
 rtl/calc_cw_decode.sv | 54 +++++
 rtl/calc_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/calc_ctrl_pkg.sv
// Shared types and constants for the calc_ctrl controller: state codes,
// opcodes, write-mux selects and the per-state datapath control word.
package calc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_LOAD_A = 3'b001,
    ST_LOAD_B = 3'b010,
    ST_EXEC   = 3'b011,
    ST_OUT    = 3'b100,
    ST_DONE   = 3'b101,
    ST_CLR    = 3'b110
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [1:0] S1_ALU  = 2'b00;
  localparam logic [1:0] S1_ZERO = 2'b01;
  localparam logic [1:0] S1_IN2  = 2'b10;
  localparam logic [1:0] S1_IN1  = 2'b11;

  localparam logic [1:0] REG_R0 = 2'b00;
  localparam logic [1:0] REG_R1 = 2'b01;
  localparam logic [1:0] REG_R2 = 2'b10;
  localparam logic [1:0] REG_R3 = 2'b11;

  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2;
  } cw_t;

  // Quiet word: write-mux parked on zero, nothing read or written.
  localparam cw_t CW_IDLE = '{
    s1:  S1_ZERO,
    wa:  REG_R0,
    we:  1'b0,
    raa: REG_R0,
    rea: 1'b0,
    rab: REG_R0,
    reb: 1'b0,
    c:   OP_ADD,
    s2:  1'b0
  };

endpackage

// File: rtl/calc_cw_decode.sv
// Combinational map from controller state and latched opcode to the
// datapath control word. CLR decoding exists only with CALC_CLEAR_ON_DONE_EN.
module calc_cw_decode
  import calc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [1:0] op_q,
  output cw_t        cw
);

  always_comb begin
    cw = CW_IDLE;
    case (state)
      ST_LOAD_A: begin
        cw.s1 = S1_IN1;
        cw.wa = REG_R1;
        cw.we = 1'b1;
      end
      ST_LOAD_B: begin
        cw.s1 = S1_IN2;
        cw.wa = REG_R2;
        cw.we = 1'b1;
      end
      ST_EXEC: begin
        cw.rea = 1'b1;
        cw.reb = 1'b1;
        cw.raa = REG_R1;
        cw.rab = REG_R2;
        cw.c   = op_q;
        cw.s1  = S1_ALU;
        cw.wa  = REG_R3;
        cw.we  = 1'b1;
      end
      // R3 AND R3 passes R3 straight through the ALU to the output mux.
      ST_OUT, ST_DONE: begin
        cw.rea = 1'b1;
        cw.reb = 1'b1;
        cw.raa = REG_R3;
        cw.rab = REG_R3;
        cw.c   = OP_AND;
        cw.s2  = 1'b1;
      end
`ifdef CALC_CLEAR_ON_DONE_EN
      ST_CLR: begin
        cw.s1 = S1_ZERO;
        cw.wa = REG_R3;
        cw.we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_ctrl.sv
// Moore controller sequencing a 3-bit register-file/ALU datapath through
// load, execute and output phases. Optional CALC_CLEAR_ON_DONE_EN adds a CLR state.
module calc_ctrl
  import calc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] op,
  output logic [1:0] s1,
  output logic [1:0] wa,
  output logic       we,
  output logic [1:0] raa,
  output logic [1:0] rab,
  output logic       rea,
  output logic       reb,
  output logic [1:0] c,
  output logic       s2,
  output logic       done,
  output logic       busy,
  output logic [2:0] cs
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] op_q;
  cw_t        cw;

  // op is captured only on the edge that accepts go, so later changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && go) begin
        op_q <= op;
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = go ? ST_LOAD_A : ST_IDLE;
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_OUT;
      ST_OUT:    state_d = ST_DONE;
`ifdef CALC_CLEAR_ON_DONE_EN
      ST_DONE:   state_d = ST_CLR;
      ST_CLR:    state_d = ST_IDLE;
`else
      ST_DONE:   state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  calc_cw_decode u_decode (
    .state (state_q),
    .op_q  (op_q),
    .cw    (cw)
  );

  always_comb begin
    s1   = cw.s1;
    wa   = cw.wa;
    we   = cw.we;
    raa  = cw.raa;
    rab  = cw.rab;
    rea  = cw.rea;
    reb  = cw.reb;
    c    = cw.c;
    s2   = cw.s2;
    done = (state_q == ST_DONE);
    busy = (state_q != ST_IDLE);
    cs   = state_q;
  end

endmodule
